// File: rtl/tag_lookup_ctrl_if.sv
// Request/response handshake bundle between a cache client and tag_lookup_ctrl.
// The master modport is the requesting client; the slave modport is the controller.
interface tag_lookup_ctrl_if #(
  parameter int TWIDTH = 12,
  parameter int AWIDTH = 3,
  parameter int OWIDTH = 2
) ();

  logic                              req_valid;
  logic                              req_ready;
  logic [TWIDTH+AWIDTH+OWIDTH-1:0]   req_addr;
  logic                              req_we;

  logic                              resp_valid;
  logic                              resp_ready;
  logic                              resp_hit;
  logic                              resp_way;
  logic                              resp_victim_dirty;
  logic [TWIDTH-1:0]                 resp_victim_tag;

  modport master (
    output req_valid,
    output req_addr,
    output req_we,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_hit,
    input  resp_way,
    input  resp_victim_dirty,
    input  resp_victim_tag
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_we,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_hit,
    output resp_way,
    output resp_victim_dirty,
    output resp_victim_tag
  );

endinterface

// File: rtl/tag_lookup_ctrl.sv
// Lookup/update controller for two synchronous-read tag RAMs of a 2-way cache.
// Optional power-up clear of both tag RAMs is enabled with `define TAG_INIT_CLEAR_EN.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   INIT    | (TAG_INIT_CLEAR_EN only) zero one set of both ways per cycle
//   IDLE    | ready for a request; capture tag/index/write on handshake
//   READ    | present idx_q to both RAMs; data returns next cycle
//   COMPARE | compare both ways, write back hit/allocated entry, update LRU
//   RESP    | hold registered response until consumed
module tag_lookup_ctrl #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 14,
  parameter int OWIDTH = 2
) (
  input  logic              clock,
  input  logic              reset,
  tag_lookup_ctrl_if.slave  bus,
  output logic [AWIDTH-1:0] tag_addr,
  output logic              t0_we,
  output logic              t1_we,
  output logic [DWIDTH-1:0] tag_din,
  input  logic [DWIDTH-1:0] t0_dout,
  input  logic [DWIDTH-1:0] t1_dout
);

  localparam int TWIDTH = DWIDTH - 2;
  localparam int DEPTH  = 1 << AWIDTH;
  localparam int IDX_LO = OWIDTH;
  localparam int TAG_LO = OWIDTH + AWIDTH;
  localparam int ADDR_W = TWIDTH + AWIDTH + OWIDTH;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    COMPARE = 3'd2,
    RESP    = 3'd3,
    INIT    = 3'd4
  } state_t;

`ifdef TAG_INIT_CLEAR_EN
  localparam state_t RESET_STATE = INIT;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t state, state_n;

  logic [TWIDTH-1:0] tag_q;
  logic [AWIDTH-1:0] idx_q;
  logic              we_q;
  logic [DEPTH-1:0]  lru;

  logic              hit_q;
  logic              way_q;
  logic              vdirty_q;
  logic [TWIDTH-1:0] vtag_q;

`ifdef TAG_INIT_CLEAR_EN
  logic [AWIDTH-1:0] init_addr;
`endif

  // Block offset plays no part in the tag compare.
  logic unused_offset;
  assign unused_offset = &{1'b0, bus.req_addr[OWIDTH-1:0]};

  logic              v0, v1;
  logic [TWIDTH-1:0] tg0, tg1;
  logic              hit0, hit1, hit, hit_way;
  logic              victim, victim_valid, victim_dirty;
  logic [TWIDTH-1:0] victim_tag;
  logic              acc_way;

  always_comb begin
    v0   = t0_dout[DWIDTH-1];
    v1   = t1_dout[DWIDTH-1];
    tg0  = t0_dout[TWIDTH-1:0];
    tg1  = t1_dout[TWIDTH-1:0];
    hit0 = v0 && (tg0 == tag_q);
    hit1 = v1 && (tg1 == tag_q);
    hit  = hit0 || hit1;
    // A double hit can only come from a corrupted set; way 0 takes it.
    hit_way = hit0 ? 1'b0 : 1'b1;

    if (!v0) begin
      victim = 1'b0;
    end else if (!v1) begin
      victim = 1'b1;
    end else begin
      victim = lru[idx_q];
    end

    victim_valid = victim ? v1 : v0;
    victim_dirty = victim ? t1_dout[DWIDTH-2] : t0_dout[DWIDTH-2];
    victim_tag   = victim ? tg1 : tg0;
    acc_way      = hit ? hit_way : victim;
  end

  always_comb begin
    state_n        = state;
    tag_addr       = '0;
    t0_we          = 1'b0;
    t1_we          = 1'b0;
    tag_din        = '0;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;

    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          state_n = READ;
        end
      end

      READ: begin
        tag_addr = idx_q;
        state_n  = COMPARE;
      end

      COMPARE: begin
        tag_addr = idx_q;
        if (hit) begin
          if (we_q) begin
            t0_we   = ~hit_way;
            t1_we   = hit_way;
            tag_din = {2'b11, tag_q};
          end
        end else begin
          t0_we   = ~victim;
          t1_we   = victim;
          tag_din = {1'b1, we_q, tag_q};
        end
        state_n = RESP;
      end

      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) begin
          state_n = IDLE;
        end
      end

`ifdef TAG_INIT_CLEAR_EN
      INIT: begin
        tag_addr = init_addr;
        // Held in INIT during reset; enables must stay low until release.
        t0_we    = ~reset;
        t1_we    = ~reset;
        if (init_addr == AWIDTH'(DEPTH - 1)) begin
          state_n = IDLE;
        end
      end
`endif

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= RESET_STATE;
      tag_q    <= '0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      lru      <= '0;
      hit_q    <= 1'b0;
      way_q    <= 1'b0;
      vdirty_q <= 1'b0;
      vtag_q   <= '0;
`ifdef TAG_INIT_CLEAR_EN
      init_addr <= '0;
`endif
    end else begin
      state <= state_n;

      if (state == IDLE && bus.req_valid) begin
        tag_q <= bus.req_addr[ADDR_W-1:TAG_LO];
        idx_q <= bus.req_addr[TAG_LO-1:IDX_LO];
        we_q  <= bus.req_we;
      end

      if (state == COMPARE) begin
        lru[idx_q] <= ~acc_way;
        hit_q      <= hit;
        way_q      <= acc_way;
        vdirty_q   <= !hit && victim_valid && victim_dirty;
        vtag_q     <= (!hit && victim_valid) ? victim_tag : '0;
      end

`ifdef TAG_INIT_CLEAR_EN
      if (state == INIT) begin
        init_addr <= init_addr + AWIDTH'(1);
      end
`endif
    end
  end

  assign bus.resp_hit          = hit_q;
  assign bus.resp_way          = way_q;
  assign bus.resp_victim_dirty = vdirty_q;
  assign bus.resp_victim_tag   = vtag_q;

endmodule
